// File: rtl/mandel_coord_gen_if.sv
// Valid/ready coordinate stream from the coordinate generator to the Mandelbrot iterator.
// An item transfers on a rising clock edge where out_valid && out_ready; while out_valid is high and out_ready low, every payload field holds stable.
interface mandel_coord_gen_if #(
    parameter int BITS   = 16,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
);
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic            out_valid;
    logic            out_ready;
    logic [BITS-1:0] out_cr;
    logic [BITS-1:0] out_ci;
    logic [XW-1:0]   out_x;
    logic [YW-1:0]   out_y;
    logic            out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_cr,
        output out_ci,
        output out_x,
        output out_y,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_cr,
        input  out_ci,
        input  out_x,
        input  out_y,
        input  out_last
    );
endinterface

// File: rtl/mandel_coord_gen.sv
// Raster-order pixel coordinate generator: walks a frame row by row, emitting fixed-point (cr, ci)
// and integer (x, y) on a valid/ready stream; view config is staged and applied at each vsync_pulse.
module mandel_coord_gen #(
    parameter int BITS   = 16,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vsync_pulse,
    input  logic signed [BITS-1:0] cfg_x0,
    input  logic signed [BITS-1:0] cfg_y0,
    input  logic signed [BITS-1:0] cfg_step,
    input  logic                   cfg_load,
    mandel_coord_gen_if.master     m,
    output logic                   overrun,
    output logic [1:0]             dbg_state
);
    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic                   r_valid;
    logic                   r_overrun;
    logic signed [BITS-1:0] r_cr;
    logic signed [BITS-1:0] r_ci;
    logic [XW-1:0]          r_x;
    logic [YW-1:0]          r_y;

    logic signed [BITS-1:0] r_stg_x0;
    logic signed [BITS-1:0] r_stg_y0;
    logic signed [BITS-1:0] r_stg_step;
    logic signed [BITS-1:0] r_act_x0;
    logic signed [BITS-1:0] r_act_step;

    logic                   w_accept;
    logic                   w_x_end;
    logic                   w_y_end;
    logic                   w_last;
    logic signed [BITS-1:0] w_new_x0;
    logic signed [BITS-1:0] w_new_y0;
    logic signed [BITS-1:0] w_new_step;

    assign w_accept = r_valid && m.out_ready;
    assign w_x_end  = (r_x == X_MAX);
    assign w_y_end  = (r_y == Y_MAX);
    assign w_last   = (r_state == RUN) && w_x_end && w_y_end;

    // A cfg_load coinciding with vsync_pulse must reach the new frame, so bypass the staging registers.
    assign w_new_x0   = cfg_load ? cfg_x0   : r_stg_x0;
    assign w_new_y0   = cfg_load ? cfg_y0   : r_stg_y0;
    assign w_new_step = cfg_load ? cfg_step : r_stg_step;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
            r_cr       <= '0;
            r_ci       <= '0;
            r_x        <= '0;
            r_y        <= '0;
            r_stg_x0   <= '0;
            r_stg_y0   <= '0;
            r_stg_step <= '0;
            r_act_x0   <= '0;
            r_act_step <= '0;
        end else begin
            r_overrun <= 1'b0;
            if (cfg_load) begin
                r_stg_x0   <= cfg_x0;
                r_stg_y0   <= cfg_y0;
                r_stg_step <= cfg_step;
            end
            if (vsync_pulse) begin
                // Restart wins over any coincident accept; the accepted item is simply dropped from the old frame.
                r_overrun  <= (r_state == RUN);
                r_act_x0   <= w_new_x0;
                r_act_step <= w_new_step;
                r_cr       <= w_new_x0;
                r_ci       <= w_new_y0;
                r_x        <= '0;
                r_y        <= '0;
                r_valid    <= 1'b1;
                r_state    <= RUN;
            end else begin
                case (r_state)
                    RUN: begin
                        if (w_accept) begin
                            if (w_x_end && w_y_end) begin
                                r_valid <= 1'b0;
                                r_state <= DONE;
                            end else if (!w_x_end) begin
                                r_x  <= r_x + 1'b1;
                                r_cr <= r_cr + r_act_step;
                            end else begin
                                r_x  <= '0;
                                r_cr <= r_act_x0;
                                r_y  <= r_y + 1'b1;
                                r_ci <= r_ci + r_act_step;
                            end
                        end
                    end
                    IDLE, DONE: begin
                        r_valid <= 1'b0;
                    end
                    default: begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign m.out_valid = r_valid;
    assign m.out_cr    = r_cr;
    assign m.out_ci    = r_ci;
    assign m.out_x     = r_x;
    assign m.out_y     = r_y;
    assign m.out_last  = w_last;
    assign overrun     = r_overrun;
    assign dbg_state   = r_state;
endmodule

// File: tb/tb_mandel_coord_gen.sv
// Scoreboarded bench for mandel_coord_gen on a 4x3 frame: raster walk, backpressure, config staging,
// same-cycle load/vsync, overrun restart, arithmetic wrap and asynchronous reset.
module tb_mandel_coord_gen;
    localparam int BITS = 16;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int IW   = 2 + 2 + 2 + BITS + BITS;

    logic            clk;
    logic            reset;
    logic            vsync_pulse;
    logic [BITS-1:0] cfg_x0;
    logic [BITS-1:0] cfg_y0;
    logic [BITS-1:0] cfg_step;
    logic            cfg_load;
    logic            overrun;
    logic [1:0]      dbg_state;

    mandel_coord_gen_if #(.BITS(BITS), .WIDTH(W), .HEIGHT(H)) bus ();

    mandel_coord_gen #(.BITS(BITS), .WIDTH(W), .HEIGHT(H)) dut (
        .clk         (clk),
        .reset       (reset),
        .vsync_pulse (vsync_pulse),
        .cfg_x0      (cfg_x0),
        .cfg_y0      (cfg_y0),
        .cfg_step    (cfg_step),
        .cfg_load    (cfg_load),
        .m           (bus),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int n_ovr = 0;
    logic [IW-1:0] exp_q[$];
    logic mon_en   = 1'b0;
    logic rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [IW-1:0] observed();
        return {bus.out_valid, bus.out_last, bus.out_x, bus.out_y, bus.out_cr, bus.out_ci};
    endfunction

    // reference model: pixel k of a frame is (x0 + x*step, y0 + y*step) modulo 2^BITS
    task automatic push_frame(input logic [BITS-1:0] x0, input logic [BITS-1:0] y0,
                              input logic [BITS-1:0] step, input int n);
        for (int k = 0; k < n; k++) begin
            int xi;
            int yi;
            logic [31:0] cr;
            logic [31:0] ci;
            logic last;
            xi   = k % W;
            yi   = k / W;
            cr   = 32'(x0) + 32'(xi) * 32'(step);
            ci   = 32'(y0) + 32'(yi) * 32'(step);
            last = (xi == W - 1) && (yi == H - 1);
            exp_q.push_back({1'b1, last, 2'(xi), 2'(yi), cr[BITS-1:0], ci[BITS-1:0]});
        end
    endtask

    // scoreboard monitor, sampling on the falling edge
    logic          stall_prev = 1'b0;
    logic [IW-1:0] prev_obs   = '0;
    always @(negedge clk) begin
        logic [IW-1:0] obs;
        obs = observed();
        if (overrun) n_ovr++;
        if (mon_en) begin
            if (stall_prev) check("stall_hold", 64'(obs), 64'(prev_obs));
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) check("unexpected_item", 64'(obs), 64'd0);
                else check("item", 64'(obs), 64'(exp_q.pop_front()));
            end
            stall_prev = bus.out_valid && !bus.out_ready;
            prev_obs   = obs;
        end else begin
            stall_prev = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            bus.out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    // driver tasks: all called at posedge+1 and return at posedge+1
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_cfg(input logic [BITS-1:0] x0, input logic [BITS-1:0] y0, input logic [BITS-1:0] step);
        cfg_x0 = x0; cfg_y0 = y0; cfg_step = step; cfg_load = 1'b1;
        tick(1);
        cfg_load = 1'b0;
    endtask

    task automatic pulse_vsync();
        vsync_pulse = 1'b1;
        tick(1);
        vsync_pulse = 1'b0;
    endtask

    task automatic wait_empty(input int budget, input logic chk_done);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        #1;
        if (i == budget) check("timeout_left", 64'(exp_q.size()), 64'd0);
        if (chk_done) begin
            check("done_valid", 64'(bus.out_valid), 64'd0);
            check("done_state", 64'(dbg_state), 64'd2);
            check("done_last", 64'(bus.out_last), 64'd0);
        end
    endtask

    initial begin
        logic found;
        reset = 1'b1; vsync_pulse = 1'b0; cfg_load = 1'b0;
        cfg_x0 = '0; cfg_y0 = '0; cfg_step = '0;
        bus.out_ready = 1'b1;
        tick(3);
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_cr", 64'(bus.out_cr), 64'd0);
        check("rst_ci", 64'(bus.out_ci), 64'd0);
        check("rst_xy", 64'({bus.out_x, bus.out_y}), 64'd0);
        check("rst_last", 64'(bus.out_last), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick(2);
        check("idle_valid", 64'(bus.out_valid), 64'd0);

        // basic raster walk
        load_cfg(16'hE000, 16'hF000, 16'h0010);
        check("pre_vsync_valid", 64'(bus.out_valid), 64'd0);
        push_frame(16'hE000, 16'hF000, 16'h0010, W * H);
        pulse_vsync();
        check("latency_valid", 64'(bus.out_valid), 64'd1);
        wait_empty(100, 1'b1);

        // backpressure
        push_frame(16'hE000, 16'hF000, 16'h0010, W * H);
        rand_rdy = 1'b1;
        pulse_vsync();
        wait_empty(400, 1'b0);
        rand_rdy = 1'b0;
        tick(1);
        bus.out_ready = 1'b1;
        tick(1);
        check("bp_done_valid", 64'(bus.out_valid), 64'd0);

        // staged config must not disturb the running frame
        push_frame(16'hE000, 16'hF000, 16'h0010, W * H);
        pulse_vsync();
        tick(3);
        load_cfg(16'hE000, 16'hF000, 16'h0020);
        wait_empty(100, 1'b1);
        push_frame(16'hE000, 16'hF000, 16'h0020, W * H);
        pulse_vsync();
        wait_empty(100, 1'b1);

        // load and vsync in the same cycle
        cfg_x0 = 16'h0100; cfg_y0 = 16'hF000; cfg_step = 16'h0020;
        cfg_load = 1'b1;
        push_frame(16'h0100, 16'hF000, 16'h0020, W * H);
        pulse_vsync();
        cfg_load = 1'b0;
        wait_empty(100, 1'b1);
        check("no_overrun_yet", 64'(n_ovr), 64'd0);

        // restart mid-frame at pixel (2,1)
        load_cfg(16'h0040, 16'h0080, 16'h0008);
        push_frame(16'h0040, 16'h0080, 16'h0008, 7);
        pulse_vsync();
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_x == 2'd2 && bus.out_y == 2'd1) begin
                found = 1'b1;
                break;
            end
        end
        check("found_2_1", 64'(found), 64'd1);
        push_frame(16'h0040, 16'h0080, 16'h0008, W * H);
        vsync_pulse = 1'b1;
        @(posedge clk);
        #1;
        vsync_pulse = 1'b0;
        @(negedge clk);
        check("overrun_pulse", 64'(overrun), 64'd1);
        @(negedge clk);
        check("overrun_single", 64'(overrun), 64'd0);
        @(posedge clk);
        #1;
        wait_empty(100, 1'b1);
        check("overrun_count", 64'(n_ovr), 64'd1);

        // wrap, then asynchronous reset mid-row
        load_cfg(16'h7FF0, 16'h0000, 16'h0010);
        push_frame(16'h7FF0, 16'h0000, 16'h0010, 2);
        pulse_vsync();
        wait_empty(20, 1'b0);
        mon_en = 1'b0;
        check("midrow_valid", 64'(bus.out_valid), 64'd1);
        check("midrow_x", 64'(bus.out_x), 64'd2);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", 64'(bus.out_valid), 64'd0);
        check("async_cr", 64'(bus.out_cr), 64'd0);
        check("async_ci", 64'(bus.out_ci), 64'd0);
        check("async_xy", 64'(bus.out_x) | 64'(bus.out_y), 64'd0);
        check("async_state", 64'(dbg_state), 64'd0);
        tick(2);
        reset = 1'b0;
        mon_en = 1'b1;
        tick(1);

        // first frame after reset runs on zeroed config
        push_frame(16'h0000, 16'h0000, 16'h0000, W * H);
        pulse_vsync();
        wait_empty(100, 1'b1);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
